// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage pipeline back end:
//   - load-type encodings carried from decode to write-back (LT_LW..LT_LHU)
//   - write-back FSM state encodings
//   - REG_ZERO, the hard-wired zero register index
//   - sign/zero extension helpers used by load alignment
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_pkg;

  // Load-type field as decoded; unlisted codes behave as a full-word load.
  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  // Write-back register-file port sequencing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

  // Register r0 reads as zero and is never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Widen a byte to a word; sign_en selects sign vs zero extension.
  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sign_en);
    extend_byte = {{24{sign_en & b[7]}}, b};
  endfunction

  // Widen a halfword to a word; sign_en selects sign vs zero extension.
  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sign_en);
    extend_half = {{16{sign_en & h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational sub-word load extraction: selects the addressed byte or
// halfword from a raw memory word and sign/zero extends it. Also flags a
// halfword load whose address is odd. Shared by the MEM and WB stages.
// Ports:
//   load_type   in  3   load-type code (LT_* in pipeline_pkg)
//   byte_offset in  2   address bits [1:0]
//   mem_data    in  32  raw word from data memory
//   load_data   out 32  aligned, extended load value
//   misaligned  out 1   LH/LHU with byte_offset[0]=1
// ---------------------------------------------------------------------------
module load_align
  import pipeline_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] mem_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  lane_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection from the address offset.
  always_comb begin
    // lane_s counts from the most significant byte; little-endian offset k
    // lives in the lane counted 3-k from the top.
    if (BIG_ENDIAN) begin
      lane_s = byte_offset;
    end else begin
      lane_s = 2'd3 - byte_offset;
    end

    case (lane_s)
      2'd0:    byte_s = mem_data[31:24];
      2'd1:    byte_s = mem_data[23:16];
      2'd2:    byte_s = mem_data[15:8];
      default: byte_s = mem_data[7:0];
    endcase

    // Halfword select ignores offset bit 0; an odd offset is only flagged.
    if (byte_offset[1] == BIG_ENDIAN) begin
      half_s = mem_data[15:0];
    end else begin
      half_s = mem_data[31:16];
    end
  end

  // Extension per load type plus the misalignment flag.
  always_comb begin
    case (load_type)
      LT_LB:   load_data = extend_byte(byte_s, 1'b1);
      LT_LBU:  load_data = extend_byte(byte_s, 1'b0);
      LT_LH:   load_data = extend_half(half_s, 1'b1);
      LT_LHU:  load_data = extend_half(half_s, 1'b0);
      default: load_data = mem_data;
    endcase

    if ((load_type == LT_LH) || (load_type == LT_LHU)) begin
      misaligned = byte_offset[0];
    end else begin
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage: MEM/WB pipeline register, result select (ALU vs aligned
// load data), register-file write port sequencing, decode bypass hits and a
// retired-instruction counter.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   stall                     hold MEM/WB contents
//   flush                     invalidate the entry at the next edge
//   in_valid .. in_memData    MEM-stage instruction fields
//   readRegister1/2           decode read indices for bypass compare
//   regWrite/writeRegister/writeData   register-file write port
//   bypassA/bypassB           writeData supersedes readData1/readData2
//   misaligned                registered odd-address halfword load flag
//   retireCount               retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module wb_stage
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic                      in_regWrite,
  input  logic                      in_memToReg,
  input  logic [2:0]                in_loadType,
  input  logic [1:0]                in_byteOffset,
  input  logic [REG_ADDR_WIDTH-1:0] in_writeRegister,
  input  logic [31:0]               in_aluResult,
  input  logic [31:0]               in_memData,
  input  logic [REG_ADDR_WIDTH-1:0] readRegister1,
  input  logic [REG_ADDR_WIDTH-1:0] readRegister2,
  output logic                      regWrite,
  output logic [REG_ADDR_WIDTH-1:0] writeRegister,
  output logic [31:0]               writeData,
  output logic                      bypassA,
  output logic                      bypassB,
  output logic                      misaligned,
  output logic [COUNT_WIDTH-1:0]    retireCount
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(REG_ZERO);

  logic [31:0]               load_data_s;
  logic                      load_mis_s;
  logic [31:0]               wdata_s;
  logic                      cap_valid_s;
  logic                      cap_write_s;
  wb_state_e                 state_r;
  wb_state_e                 state_s;
  logic                      valid_r;
  logic [REG_ADDR_WIDTH-1:0] wreg_r;
  logic [31:0]               wdata_r;
  logic                      mis_r;
  logic [COUNT_WIDTH-1:0]    count_r;

  load_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_load_align (
    .load_type   (in_loadType),
    .byte_offset (in_byteOffset),
    .mem_data    (in_memData),
    .load_data   (load_data_s),
    .misaligned  (load_mis_s)
  );

  // Result select and qualification of the entry offered for capture.
  always_comb begin
    if (in_memToReg) begin
      wdata_s = load_data_s;
    end else begin
      wdata_s = in_aluResult;
    end
    cap_valid_s = in_valid & ~flush;
    cap_write_s = cap_valid_s & in_regWrite & (in_writeRegister != ZERO_IDX);
  end

  // Write FSM next state: WRITE lasts one cycle, a stall parks it in HOLD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (stall) begin
          state_s = state_r;
        end else if (cap_write_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (stall) begin
          state_s = ST_HOLD;
        end else if (cap_write_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // MEM/WB register: capture when not stalled; flush alone clears valid while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      wreg_r  <= '0;
      wdata_r <= 32'd0;
      mis_r   <= 1'b0;
    end else if (!stall) begin
      valid_r <= cap_valid_s;
      wreg_r  <= in_writeRegister;
      wdata_r <= wdata_s;
      mis_r   <= load_mis_s & in_memToReg & cap_valid_s;
    end else if (flush) begin
      valid_r <= 1'b0;
    end
  end

  // Retire counter: each valid entry counts once, when it is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (!stall && cap_valid_s) begin
      count_r <= count_r + COUNT_WIDTH'(1);
    end
  end

  // A WRITE state always holds a valid entry; gating on valid_r keeps the
  // strobe off even if the state register were ever corrupted.
  assign regWrite      = (state_r == ST_WRITE) & valid_r;
  assign writeRegister = wreg_r;
  assign writeData     = wdata_r;
  assign misaligned    = mis_r;
  assign retireCount   = count_r;

  assign bypassA = regWrite & (wreg_r == readRegister1) & (readRegister1 != ZERO_IDX);
  assign bypassB = regWrite & (wreg_r == readRegister2) & (readRegister2 != ZERO_IDX);

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Directed self-checking bench for wb_stage with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_regWrite;
  logic        in_memToReg;
  logic [2:0]  in_loadType;
  logic [1:0]  in_byteOffset;
  logic [4:0]  in_writeRegister;
  logic [31:0] in_aluResult;
  logic [31:0] in_memData;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        bypassA;
  logic        bypassB;
  logic        misaligned;
  logic [31:0] retireCount;

  int errors = 0;
  int checks = 0;

  wb_stage #(
    .REG_ADDR_WIDTH (5),
    .COUNT_WIDTH    (32),
    .BIG_ENDIAN     (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_regWrite      (in_regWrite),
    .in_memToReg      (in_memToReg),
    .in_loadType      (in_loadType),
    .in_byteOffset    (in_byteOffset),
    .in_writeRegister (in_writeRegister),
    .in_aluResult     (in_aluResult),
    .in_memData       (in_memData),
    .readRegister1    (readRegister1),
    .readRegister2    (readRegister2),
    .regWrite         (regWrite),
    .writeRegister    (writeRegister),
    .writeData        (writeData),
    .bypassA          (bypassA),
    .bypassB          (bypassB),
    .misaligned       (misaligned),
    .retireCount      (retireCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem);
    in_valid         = v;
    in_regWrite      = rw;
    in_memToReg      = m2r;
    in_loadType      = lt;
    in_byteOffset    = off;
    in_writeRegister = rd;
    in_aluResult     = alu;
    in_memData       = mem;
  endtask

  logic [2:0]  ld_type [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
  logic [1:0]  ld_off  [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'hFFFF80FF};
  logic        ld_mis  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    readRegister1 = 5'd0;
    readRegister2 = 5'd0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("rst_writeReg", {27'd0, writeRegister}, 32'd0);
    check_eq("rst_writeData", writeData, 32'd0);
    check_eq("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check_eq("rst_retire", retireCount, 32'd0);

    // ALU result write
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h00000123, 32'd0);
    step();
    check_eq("alu_regWrite", {31'd0, regWrite}, 32'd1);
    check_eq("alu_writeReg", {27'd0, writeRegister}, 32'd5);
    check_eq("alu_writeData", writeData, 32'h00000123);
    check_eq("alu_retire", retireCount, 32'd1);
    in_valid = 1'b0;
    step();
    check_eq("alu_one_cycle", {31'd0, regWrite}, 32'd0);

    // Loads, back to back
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, ld_type[i], ld_off[i], 5'(10 + i), 32'h0BAD0BAD, 32'h80FF7F01);
      step();
      check_eq($sformatf("load%0d_data", i), writeData, ld_exp[i]);
      check_eq($sformatf("load%0d_regWrite", i), {31'd0, regWrite}, 32'd1);
      check_eq($sformatf("load%0d_mis", i), {31'd0, misaligned}, {31'd0, ld_mis[i]});
      check_eq($sformatf("load%0d_retire", i), retireCount, 32'(2 + i));
    end

    // r0 destination
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'hDEADBEEF, 32'd0);
    step();
    check_eq("r0_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("r0_writeData", writeData, 32'hDEADBEEF);
    check_eq("r0_retire", retireCount, 32'd7);
    in_valid = 1'b0;
    step();
    check_eq("idle_retire", retireCount, 32'd7);

    // Write to r7, bypass, then stall 3 cycles
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 32'h00000077, 32'd0);
    step();
    check_eq("r7_regWrite", {31'd0, regWrite}, 32'd1);
    check_eq("r7_retire", retireCount, 32'd8);
    readRegister1 = 5'd7;
    readRegister2 = 5'd8;
    #1;
    check_eq("bypassA_hit", {31'd0, bypassA}, 32'd1);
    check_eq("bypassB_miss", {31'd0, bypassB}, 32'd0);
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h00000099, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall%0d_regWrite", i), {31'd0, regWrite}, 32'd0);
      check_eq($sformatf("stall%0d_writeData", i), writeData, 32'h00000077);
      check_eq($sformatf("stall%0d_writeReg", i), {27'd0, writeRegister}, 32'd7);
      check_eq($sformatf("stall%0d_retire", i), retireCount, 32'd8);
      check_eq($sformatf("stall%0d_bypassA", i), {31'd0, bypassA}, 32'd0);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    step();
    check_eq("unstall_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("unstall_retire", retireCount, 32'd8);

    // Flush together with stall, then flush alone
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h00000099, 32'd0);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check_eq("flushstall_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("flushstall_retire", retireCount, 32'd8);
    stall = 1'b0;
    step();
    check_eq("flush_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("flush_retire", retireCount, 32'd8);
    check_eq("flush_writeData", writeData, 32'h00000099);
    flush = 1'b0;
    step();
    check_eq("postflush_regWrite", {31'd0, regWrite}, 32'd1);
    check_eq("postflush_retire", retireCount, 32'd9);

    // Asynchronous reset mid-stream while regWrite=1
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_regWrite", {31'd0, regWrite}, 32'd0);
    check_eq("async_writeData", writeData, 32'd0);
    check_eq("async_writeReg", {27'd0, writeRegister}, 32'd0);
    check_eq("async_retire", retireCount, 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage pipeline. It is the producing end of the register-file write port (regWrite/writeRegister/writeData) that the decode-stage register file consumes.
- Holds the MEM/WB pipeline register.
- Selects the ALU result or aligned/extended load data.
- Issues exactly one register-file write per retired instruction.
- Drives bypass hits for the decode-stage read ports.
- Counts retired instructions.

Parameters:
REG_ADDR_WIDTH, 5, register index width
COUNT_WIDTH, 32, retire counter width
BIG_ENDIAN, 1, byte lane order for sub-word loads (1: offset 0 = bits 31:24)

Ports:
clock  in  1  pipeline clock, rising-edge active
reset  in  1  asynchronous, active-high reset
stall  in  1  hold MEM/WB register contents
flush  in  1  invalidate entry captured at next edge
in_valid  in  1  MEM stage holds a real instruction
in_regWrite  in  1  instruction writes a register
in_memToReg  in  1  1: write load data, 0: write ALU result
in_loadType  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, others treated as LW
in_byteOffset  in  2  address bits [1:0] of the load
in_writeRegister  in  5  destination register
in_aluResult  in  32  ALU result
in_memData  in  32  raw word from data memory
readRegister1  in  5  decode read index A (bypass compare)
readRegister2  in  5  decode read index B (bypass compare)
regWrite  out  1  register-file write strobe
writeRegister  out  5  write index
writeData  out  32  signed write value
bypassA  out  1  writeData supersedes readData1 this cycle
bypassB  out  1  writeData supersedes readData2 this cycle
misaligned  out  1  halfword load with byteOffset[0]=1
retireCount  out  COUNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, high) values: valid=0, state IDLE, regWrite=0, writeRegister=0, writeData=0, bypassA/B=0, misaligned=0, retireCount=0.
- Capture at rising edge when !stall:
  - Stored fields: valid<=in_valid&!flush, plus all in_* fields.
  - Load extraction and the memToReg mux are computed before the register; writeData is a registered value.
  - Latency: 1 cycle from MEM inputs to write-port outputs.
- flush has priority over stall: with flush=1 the valid bit clears at the edge even when stall=1; data fields are held.
- Load extraction (BIG_ENDIAN=1):
  - Byte lane k = bits [31-8k:24-8k].
  - Halfword uses byteOffset[1] only: 0 -> [31:16], 1 -> [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - BIG_ENDIAN=0 mirrors the lane order.
  - misaligned=1 for LH/LHU with byteOffset[0]=1. The data is still written; misaligned is registered alongside the entry.
- Write FSM, states IDLE / WRITE / HOLD:
  - IDLE -> WRITE on capture of an entry with valid & regWrite & writeRegister!=0.
  - WRITE: regWrite=1 for exactly one cycle. Then go to HOLD if stall=1; otherwise go to WRITE or IDLE per the next captured entry.
  - HOLD: regWrite=0 and outputs stable until stall drops; then accept the next entry as from IDLE.
  - A register-0 destination or regWrite=0 entry never asserts regWrite.
  - A flushed entry never asserts regWrite.
- Bypass:
  - bypassA = regWrite & (writeRegister==readRegister1) & readRegister1!=0. bypassB is the same using readRegister2.
  - Combinational on the read indices.
- retireCount increments by 1 on the cycle an entry with valid=1 enters WRITE, or leaves the stage without writing. Stalled repeats never count. Wraps modulo 2^COUNT_WIDTH.
- writeData changes only on capture, so a consumer that triggers on data changes sees one write per instruction.

Decomposition:
- Shared package, pipeline_pkg:
  - load-type encodings LT_LW..LT_LHU
  - FSM state encodings
  - REG_ZERO constant
- One sub-module: load_align (combinational byte/halfword select plus sign/zero extension, with a misaligned flag). Also reusable by the MEM stage.

Test Plan:
1. Reset mid-stream with regWrite=1 -> regWrite=0, writeData=0, retireCount=0 immediately, without waiting for a clock.
2. ALU op: in_aluResult=0x00000123, rd=5, memToReg=0 -> next cycle regWrite=1 (one cycle), writeRegister=5, writeData=0x00000123, retireCount=1.
3. Loads with memData=0x80FF7F01:
   - LB offset 0 -> 0xFFFFFF80
   - LBU offset 0 -> 0x00000080
   - LH offset 2 -> 0x00007F01
   - LHU offset 0 -> 0x000080FF
   - LH offset 1 -> misaligned=1, data 0xFFFF80FF
4. Write to rd=0 with value 0xDEADBEEF -> regWrite stays 0; retireCount still increments.
5. Stall held 3 cycles after capturing an rd=7 entry -> regWrite high exactly 1 cycle; writeData stable; retireCount +1 only.
6. Simultaneous flush+stall -> no write; readRegister1=7 during a WRITE to r7 -> bypassA=1, bypassB=0 with readRegister2=8.
